// File: rtl/sar_pkg.sv
// Shared types and width helpers for the SAR ADC sequencer and its accumulator.
package sar_pkg;

   localparam int SAR_N_BITS = 10;

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      SETTLE,
      PUSH
   } seq_state_e;

   // Accumulator is wide enough for 2^avg_log2 full-scale samples.
   function automatic int acc_width(input int n_bits, input int avg_log2);
      return n_bits + avg_log2;
   endfunction

endpackage

// File: rtl/sar_avg_accum.sv
// Sums 2^AVG_LOG2 ADC samples and presents the truncated average of the set
// that completes with the current sample.
module sar_avg_accum
   import sar_pkg::*;
#(
   parameter int N_BITS   = SAR_N_BITS,
   parameter int AVG_LOG2 = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              add_i,
   input  logic              clear_i,
   input  logic [N_BITS-1:0] sample_i,
   output logic              done_o,
   output logic [N_BITS-1:0] avg_o
);

   localparam int ACC_W = acc_width(N_BITS, AVG_LOG2);
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << AVG_LOG2) - 1);

   logic [ACC_W-1:0] acc_q, acc_d, sum;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign sum    = acc_q + ACC_W'(sample_i);
   assign done_o = add_i && (cnt_q == LAST_IDX);
   assign avg_o  = N_BITS'(sum >> AVG_LOG2);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (clear_i || done_o) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (add_i) begin
         acc_d = sum;
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sar_conv_sequencer.sv
// Drives the SAR ADC hold/eoc handshake, averages results and streams them out
// on valid/ready, with a conversion timeout guarding against a stuck converter.
module sar_conv_sequencer
   import sar_pkg::*;
#(
   parameter int N_BITS         = SAR_N_BITS,
   parameter int AVG_LOG2       = 2,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   output logic              adc_hold,
   input  logic              adc_eoc,
   input  logic [N_BITS-1:0] adc_result,
   output logic [N_BITS-1:0] avg_data,
   output logic              avg_valid,
   input  logic              avg_ready,
   output logic              timeout_err,
   input  logic              err_clear
);

   localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   seq_state_e        state_q, state_d;
   logic              eoc_q;
   logic              eoc_rise;
   logic [TO_W-1:0]   to_q, to_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              sample_add;
   logic              timeout_hit;
   logic              acc_clear;
   logic              acc_done;
   logic              push_load;
   logic [N_BITS-1:0] acc_avg;
   logic [N_BITS-1:0] avg_data_q;
   logic              avg_valid_q;
   logic              err_q;

   // A stale eoc still high from the previous conversion never counts; only a rise does.
   assign eoc_rise    = adc_eoc & ~eoc_q;
   assign sample_add  = (state_q == CONVERT) & eoc_rise;
   assign timeout_hit = (state_q == CONVERT) & ~eoc_rise &
                        (to_q == TO_W'(TIMEOUT_CYCLES - 1));
   assign push_load   = sample_add & acc_done;

   sar_avg_accum #(
      .N_BITS   (N_BITS),
      .AVG_LOG2 (AVG_LOG2)
   ) u_accum (
      .clk      (clk),
      .reset    (reset),
      .add_i    (sample_add),
      .clear_i  (acc_clear),
      .sample_i (adc_result),
      .done_o   (acc_done),
      .avg_o    (acc_avg)
   );

   always_comb begin
      state_d   = state_q;
      to_d      = '0;
      gap_d     = '0;
      acc_clear = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) state_d = CONVERT;
         end
         CONVERT: begin
            if (sample_add) begin
               state_d = acc_done ? PUSH : SETTLE;
            end else if (timeout_hit) begin
               state_d   = SETTLE;
               acc_clear = 1'b1;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         SETTLE: begin
            if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
               if (enable) begin
                  state_d = CONVERT;
               end else begin
                  state_d   = IDLE;
                  acc_clear = 1'b1;
               end
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         PUSH: begin
            if (avg_ready) state_d = SETTLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         eoc_q       <= 1'b0;
         to_q        <= '0;
         gap_q       <= '0;
         avg_data_q  <= '0;
         avg_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         eoc_q   <= adc_eoc;
         to_q    <= to_d;
         gap_q   <= gap_d;
         if (push_load) begin
            avg_data_q  <= acc_avg;
            avg_valid_q <= 1'b1;
         end else if ((state_q == PUSH) && avg_ready) begin
            avg_valid_q <= 1'b0;
         end
         // A timeout in the same cycle as err_clear keeps the flag set.
         if (timeout_hit) begin
            err_q <= 1'b1;
         end else if (err_clear) begin
            err_q <= 1'b0;
         end
      end
   end

   assign adc_hold    = (state_q == CONVERT);
   assign avg_data    = avg_data_q;
   assign avg_valid   = avg_valid_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Directed bench for sar_conv_sequencer: averaging, backpressure, timeout,
// enable drop, async reset and a pass-through full-scale instance.
module tb_sar_conv_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable, avg_ready, err_clear;
   logic       adc_hold, adc_eoc, avg_valid, timeout_err;
   logic [9:0] adc_result, avg_data;

   logic       enable2;
   logic       adc_hold2, adc_eoc2, avg_valid2, timeout_err2;
   logic [9:0] adc_result2, avg_data2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sar_conv_sequencer #(
      .N_BITS(10), .AVG_LOG2(2), .GAP_CYCLES(4), .TIMEOUT_CYCLES(64)
   ) dut (
      .clk(clk), .reset(rst_n), .enable(enable), .adc_hold(adc_hold),
      .adc_eoc(adc_eoc), .adc_result(adc_result), .avg_data(avg_data),
      .avg_valid(avg_valid), .avg_ready(avg_ready), .timeout_err(timeout_err),
      .err_clear(err_clear)
   );

   sar_conv_sequencer #(
      .N_BITS(10), .AVG_LOG2(0), .GAP_CYCLES(4), .TIMEOUT_CYCLES(64)
   ) dut_pt (
      .clk(clk), .reset(rst_n), .enable(enable2), .adc_hold(adc_hold2),
      .adc_eoc(adc_eoc2), .adc_result(adc_result2), .avg_data(avg_data2),
      .avg_valid(avg_valid2), .avg_ready(1'b1), .timeout_err(timeout_err2),
      .err_clear(1'b0)
   );

   // ADC model: per conversion, eoc rises D hold-cycles after hold rises (D=0: never).
   int         dly_q[$];
   logic [9:0] val_q[$];
   int         cur_dly, hold_cnt, conv_count;
   logic [9:0] cur_val;
   logic       hold_prev;

   always @(negedge clk) begin
      if (!rst_n) begin
         hold_prev = 1'b0; hold_cnt = 0; conv_count = 0; cur_dly = 0;
         cur_val = '0; adc_eoc = 1'b0; adc_result = '0;
      end else begin
         if (adc_hold && !hold_prev) begin
            conv_count++;
            hold_cnt = 0;
            if (dly_q.size() > 0) begin
               cur_dly = dly_q.pop_front();
               cur_val = val_q.pop_front();
            end else begin
               cur_dly = 8;
               cur_val = '0;
            end
         end
         hold_prev = adc_hold;
         if (adc_hold) begin
            hold_cnt++;
            if (cur_dly != 0 && hold_cnt == cur_dly) begin
               adc_eoc    = 1'b1;
               adc_result = cur_val;
            end
         end else begin
            adc_eoc = 1'b0;
         end
      end
   end

   // Observer for the main instance: transfers, hold run lengths, valid width.
   logic [9:0] xfers[$];
   int         gaps[$];
   int         highs[$];
   int         low_run, high_run, valid_cycles;
   logic       seen_high;

   always @(negedge clk) begin
      if (!rst_n) begin
         xfers.delete(); gaps.delete(); highs.delete();
         low_run = 0; high_run = 0; valid_cycles = 0; seen_high = 1'b0;
      end else begin
         if (avg_valid) valid_cycles++;
         if (avg_valid && avg_ready) xfers.push_back(avg_data);
         if (adc_hold) begin
            if (seen_high && low_run > 0) gaps.push_back(low_run);
            low_run = 0;
            high_run++;
            seen_high = 1'b1;
         end else begin
            if (high_run > 0) highs.push_back(high_run);
            high_run = 0;
            low_run++;
         end
      end
   end

   // Pass-through instance: ADC always returns full scale, eoc 3 cycles after hold.
   int   h2 = 0, conv2 = 0, xfer2 = 0, bad2 = 0;
   logic hold2_prev = 1'b0;

   always @(negedge clk) begin
      adc_result2 = 10'h3FF;
      if (!rst_n) begin
         h2 = 0; adc_eoc2 = 1'b0; hold2_prev = 1'b0;
      end else begin
         if (adc_hold2 && !hold2_prev) conv2++;
         hold2_prev = adc_hold2;
         if (avg_valid2) begin
            xfer2++;
            if (avg_data2 != 10'd1023) bad2++;
         end
         if (!adc_hold2) begin
            h2 = 0; adc_eoc2 = 1'b0;
         end else begin
            h2++;
            if (h2 == 3) adc_eoc2 = 1'b1;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; enable = 1'b0; avg_ready = 1'b1; err_clear = 1'b0;
      dly_q.delete(); val_q.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic queue_conv(input int dly, input logic [9:0] val);
      dly_q.push_back(dly);
      val_q.push_back(val);
   endtask

   task automatic wait_xfers(input int n, input int budget, input string name);
      int t = 0;
      while (xfers.size() < n && t < budget) begin
         @(negedge clk);
         t++;
      end
      if (xfers.size() < n) begin
         checks++; failures++;
         $display("FAIL %s: waited %0d cycles, got %0d transfers, required %0d", name, t, xfers.size(), n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; avg_ready = 1'b1; err_clear = 1'b0; enable2 = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (adc_hold !== 1'b0) begin failures++; $display("FAIL rst_hold: got %b want 0", adc_hold); end
      checks++; if (avg_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", avg_valid); end
      checks++; if (avg_data !== 10'd0) begin failures++; $display("FAIL rst_data: got %0d want 0", avg_data); end
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b want 0", timeout_err); end
      checks++; if (adc_hold2 !== 1'b0) begin failures++; $display("FAIL rst_hold_pt: got %b want 0", adc_hold2); end
   endtask

   task automatic test_basic_average();
      apply_reset();
      for (int i = 0; i < 4; i++) queue_conv(8, 10'(100 + i));
      enable = 1'b1;
      wait_xfers(1, 200, "basic_wait");
      drive_edge();
      enable = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if (xfers.size() != 1 || xfers[0] !== 10'd101) begin
         failures++; $display("FAIL basic_avg: got %0d (n=%0d) want 101", xfers[0], xfers.size());
      end
      for (int i = 0; i < 3; i++) begin
         checks++; if (gaps[i] != 4) begin failures++; $display("FAIL basic_gap%0d: got %0d want 4", i, gaps[i]); end
      end
      checks++; if (highs[0] != 8) begin failures++; $display("FAIL basic_hold_len: got %0d want 8", highs[0]); end
      checks++; if (valid_cycles != 1) begin failures++; $display("FAIL basic_valid_width: got %0d want 1", valid_cycles); end
   endtask

   task automatic test_backpressure();
      int t = 0, bad = 0, low = 0;
      logic v_after;
      apply_reset();
      queue_conv(8, 10'd10); queue_conv(8, 10'd20); queue_conv(8, 10'd30); queue_conv(8, 10'd40);
      avg_ready = 1'b0;
      enable    = 1'b1;
      while (avg_valid !== 1'b1 && t < 200) begin @(negedge clk); t++; end
      checks++; if (avg_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_rise: got %b want 1", avg_valid); end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (avg_valid !== 1'b1 || avg_data !== 10'd25 || adc_hold !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); end
      drive_edge();
      avg_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      v_after = avg_valid;
      while (adc_hold !== 1'b1 && low < 20) begin low++; @(negedge clk); end
      enable = 1'b0;
      checks++; if (v_after !== 1'b0) begin failures++; $display("FAIL bp_valid_fall: got %b want 0", v_after); end
      checks++; if (low != 4) begin failures++; $display("FAIL bp_resume_gap: got %0d want 4", low); end
      checks++; if (xfers.size() != 1 || xfers[0] !== 10'd25) begin
         failures++; $display("FAIL bp_data: got %0d (n=%0d) want 25", xfers[0], xfers.size());
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_timeout();
      int t = 0;
      // Exact timeout cycle, with err_clear coinciding with the timeout.
      apply_reset();
      queue_conv(0, 10'd0);
      enable = 1'b1;
      while (adc_hold !== 1'b1 && t < 20) begin @(negedge clk); t++; end
      repeat (62) @(negedge clk);
      checks++; if (timeout_err !== 1'b0 || adc_hold !== 1'b1) begin
         failures++; $display("FAIL to_cycle62: got err=%b hold=%b want err=0 hold=1", timeout_err, adc_hold);
      end
      drive_edge();
      err_clear = 1'b1;
      drive_edge();
      err_clear = 1'b0;
      enable    = 1'b0;
      @(negedge clk);
      checks++; if (timeout_err !== 1'b1 || adc_hold !== 1'b0) begin
         failures++; $display("FAIL to_set_wins: got err=%b hold=%b want err=1 hold=0", timeout_err, adc_hold);
      end
      repeat (5) @(negedge clk);
      checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
      drive_edge();
      err_clear = 1'b1;
      drive_edge();
      err_clear = 1'b0;
      @(negedge clk);
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_clear: got %b want 0", timeout_err); end

      // Partial average is discarded by the timeout.
      apply_reset();
      queue_conv(8, 10'd500);
      queue_conv(0, 10'd0);
      for (int i = 0; i < 4; i++) queue_conv(8, 10'd100);
      enable = 1'b1;
      wait_xfers(1, 400, "to_discard_wait");
      drive_edge();
      enable = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if (highs[1] != 64) begin failures++; $display("FAIL to_hold_len: got %0d want 64", highs[1]); end
      checks++; if (xfers[0] !== 10'd100) begin failures++; $display("FAIL to_discard: got %0d want 100", xfers[0]); end
      checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_flag: got %b want 1", timeout_err); end

      // eoc rise in the timeout cycle: the sample wins.
      apply_reset();
      queue_conv(64, 10'd200);
      for (int i = 0; i < 3; i++) queue_conv(8, 10'd200);
      enable = 1'b1;
      wait_xfers(1, 400, "race_wait");
      drive_edge();
      enable = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if (highs[0] != 64) begin failures++; $display("FAIL race_hold_len: got %0d want 64", highs[0]); end
      checks++; if (xfers[0] !== 10'd200) begin failures++; $display("FAIL race_data: got %0d want 200", xfers[0]); end
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL race_err: got %b want 0", timeout_err); end
   endtask

   task automatic test_enable_drop();
      int t = 0;
      apply_reset();
      for (int i = 0; i < 3; i++) queue_conv(8, 10'd300);
      for (int i = 0; i < 4; i++) queue_conv(8, 10'(40 + i));
      enable = 1'b1;
      while (!(conv_count == 3 && adc_hold === 1'b1) && t < 200) begin @(negedge clk); t++; end
      drive_edge();
      enable = 1'b0;
      repeat (40) @(negedge clk);
      checks++; if (conv_count != 3 || xfers.size() != 0 || adc_hold !== 1'b0) begin
         failures++; $display("FAIL drop_idle: got conv=%0d xfers=%0d hold=%b want 3 0 0", conv_count, xfers.size(), adc_hold);
      end
      checks++; if (highs.size() != 3 || highs[2] != 8) begin
         failures++; $display("FAIL drop_complete: got n=%0d len=%0d want 3 8", highs.size(), highs[2]);
      end
      drive_edge();
      enable = 1'b1;
      wait_xfers(1, 200, "drop_wait");
      drive_edge();
      enable = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (xfers[0] !== 10'd41) begin failures++; $display("FAIL drop_fresh_avg: got %0d want 41", xfers[0]); end
   endtask

   task automatic test_async_reset();
      int t = 0;
      apply_reset();
      queue_conv(0, 10'd0);
      queue_conv(0, 10'd0);
      enable = 1'b1;
      while (!(timeout_err === 1'b1 && adc_hold === 1'b1) && t < 300) begin @(negedge clk); t++; end
      checks++; if (timeout_err !== 1'b1 || adc_hold !== 1'b1) begin
         failures++; $display("FAIL ar_setup: got err=%b hold=%b want 1 1", timeout_err, adc_hold);
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (adc_hold !== 1'b0 || avg_valid !== 1'b0 || timeout_err !== 1'b0) begin
         failures++; $display("FAIL ar_async: got hold=%b valid=%b err=%b want 0 0 0", adc_hold, avg_valid, timeout_err);
      end
      apply_reset();
   endtask

   task automatic test_passthrough();
      int t = 0;
      apply_reset();
      enable2 = 1'b1;
      while (xfer2 < 3 && t < 200) begin @(negedge clk); t++; end
      drive_edge();
      enable2 = 1'b0;
      repeat (20) @(negedge clk);
      checks++; if (xfer2 < 3) begin failures++; $display("FAIL pt_count: got %0d want >=3", xfer2); end
      checks++; if (bad2 != 0) begin failures++; $display("FAIL pt_fullscale: got %0d bad outputs want 0", bad2); end
      checks++; if (xfer2 != conv2) begin failures++; $display("FAIL pt_one_per_conv: got %0d outputs for %0d conversions", xfer2, conv2); end
      checks++; if (avg_data2 !== 10'd1023) begin failures++; $display("FAIL pt_data: got %0d want 1023", avg_data2); end
   endtask

   initial begin
      test_reset();
      test_basic_average();
      test_backpressure();
      test_timeout();
      test_enable_drop();
      test_async_reset();
      test_passthrough();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sar_conv_sequencer.md
Name: sar_conv_sequencer

Overview:
- Control and collection stage wrapped around the SAR ADC core.
- Upstream side: drives the ADC's hold input and waits for end-of-conversion.
- Downstream side: captures each result on the eoc rising edge, averages 2^AVG_LOG2 results, and presents the average on a valid/ready stream.
- Adds a conversion timeout so a stuck converter cannot hang the pipeline.

Parameters:
- N_BITS, 10: ADC result width; also the width of the average output.
- AVG_LOG2, 2: log2 of the number of samples per average; 0 means pass-through with one sample per output.
- GAP_CYCLES, 4: clk cycles that adc_hold stays low between conversions; minimum 1.
- TIMEOUT_CYCLES, 64: maximum clk cycles in CONVERT without an eoc rise before abort.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- enable  in  1  run request; level-sensitive.
- adc_hold  out  1  to ADC input_hold_digital; high while a conversion is requested.
- adc_eoc  in  1  ADC end-of-conversion; synchronous to clk.
- adc_result  in  N_BITS  ADC output_result_digital.
- avg_data  out  N_BITS  averaged result.
- avg_valid  out  1  avg_data is valid.
- avg_ready  in  1  consumer accepts avg_data.
- timeout_err  out  1  sticky flag: a conversion timed out.
- err_clear  in  1  one-cycle pulse that clears timeout_err.

Behaviour:
- Reset, asynchronous while reset is low:
  - state=IDLE; adc_hold=0, avg_valid=0, avg_data=0, timeout_err=0.
  - Accumulator, sample count, gap counter, timeout counter and eoc_q all 0.
- eoc_rise = adc_eoc & !eoc_q, where eoc_q is adc_eoc registered each clk.
- States: IDLE, CONVERT, SETTLE, PUSH.
- IDLE:
  - adc_hold=0.
  - enable=1 moves to CONVERT next cycle; adc_hold rises in that same edge.
- CONVERT:
  - adc_hold=1; the timeout counter increments each cycle.
  - On eoc_rise:
    - acc += adc_result, zero-extended to N_BITS+AVG_LOG2.
    - count += 1.
    - adc_hold drops on the next edge.
  - If count reaches 2^AVG_LOG2, go to PUSH. Otherwise go to SETTLE.
- Timeout in CONVERT:
  - Triggered when the counter reaches TIMEOUT_CYCLES-1 without an eoc_rise.
  - Sets timeout_err, drops adc_hold, and clears acc and count (partial average discarded).
  - Next state is SETTLE.
- SETTLE:
  - adc_hold=0 for exactly GAP_CYCLES cycles.
  - Then go to CONVERT if enable=1.
  - If enable=0, go to IDLE and clear acc and count.
- PUSH:
  - On entry: avg_data = acc >> AVG_LOG2 (truncating), avg_valid=1, then acc and count are cleared.
  - Remain in PUSH until avg_valid & avg_ready, then go to SETTLE.
  - No conversion starts while an average is unaccepted; adc_hold=0.
- Handshake:
  - avg_valid and avg_data are stable until accepted.
  - avg_valid falls on the edge after the transfer.
  - Ready may be high before valid; the transfer then occurs in the first cycle valid is high.
- enable dropping mid-CONVERT: the conversion completes (or times out) normally. The sample is still accumulated; the partial average is discarded at SETTLE exit.
- eoc_rise in the same cycle the timeout is reached: the sample wins and the timeout is not flagged.
- err_clear in the same cycle as a new timeout: set wins and timeout_err stays 1.
- adc_eoc high on entry to CONVERT (stale eoc from the previous conversion): ignored because only a rise counts. The ADC must drop eoc within GAP_CYCLES; otherwise a timeout results.
- Width:
  - Accumulator width is N_BITS+AVG_LOG2 and cannot overflow.
  - The average is always at most 2^N_BITS-1.
- Timeout counter width is $clog2(TIMEOUT_CYCLES)+1.

Decomposition:
- Package sar_pkg holds:
  - the state enum seq_state_e (IDLE, CONVERT, SETTLE, PUSH);
  - ACC_W = N_BITS+AVG_LOG2 as a function-computed localparam helper;
  - the default N_BITS constant shared with the ADC core.
- One natural sub-module: sar_avg_accum, holding the accumulator, sample counter, done flag and shift-divide output. The sequencer FSM, timeout, gap counter and handshake stay in the top level.

Test Plan:
- Basic average (AVG_LOG2=2, GAP_CYCLES=4, avg_ready=1):
  - Stimulus: ADC model returns 100, 101, 102, 103 with eoc 8 cycles after each hold rise.
  - Response: one avg_valid pulse with avg_data=101 (406>>2); adc_hold is low for exactly 4 cycles between conversions.
- Backpressure:
  - Stimulus: avg_ready=0 for 20 cycles after avg_valid rises.
  - Response: avg_data and avg_valid stay stable, adc_hold stays 0; conversions resume GAP_CYCLES after the accepting cycle.
- Timeout:
  - Stimulus: ADC never raises eoc.
  - Response: at cycle TIMEOUT_CYCLES-1=63 of CONVERT, timeout_err=1, adc_hold=0, and the accumulator is cleared. err_clear clears the flag.
  - Race case: eoc rise and timeout in the same cycle, with the ADC returning 200 → the sample is accumulated and timeout_err=0.
- Enable drop:
  - Stimulus: enable falls during the 3rd conversion.
  - Response: that conversion completes, no avg_valid is produced, the FSM reaches IDLE, and the next run produces an average from 4 fresh samples only.
- Asynchronous reset mid-CONVERT:
  - Stimulus: reset=0 asserted between clk edges.
  - Response: adc_hold, avg_valid and timeout_err go to 0 immediately, without a clk edge.
- Pass-through and full-scale (AVG_LOG2=0):
  - Stimulus: ADC returns 1023 with N_BITS=10.
  - Response: avg_data=1023 after every single conversion, with no overflow.
